// File: rtl/spi_oled_rx_pkg.sv
// Shared constants and types for the OLED SPI receiver and its byte FIFO.
package spi_oled_rx_pkg;

  localparam int SPI_BITS = 8;
  localparam int ENTRY_W  = SPI_BITS + 1;  // {DC, byte}

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } rx_state_e;

  // Idle bus levels, so releasing reset never produces a false edge
  localparam logic SYNC_RST_SCLK = 1'b0;
  localparam logic SYNC_RST_CS   = 1'b1;
  localparam logic SYNC_RST_DC   = 1'b0;
  localparam logic SYNC_RST_DIN  = 1'b0;

endpackage

// File: rtl/spi_oled_rx_fifo.sv
// Synchronous byte FIFO with a registered head entry; DEPTH must be a power of two.
module spi_rx_fifo
  import spi_oled_rx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               push_i,
  input  logic [ENTRY_W-1:0] wdata_i,
  input  logic               pop_i,
  output logic [ENTRY_W-1:0] rdata_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_MASK = AW'(DEPTH - 1);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]        cnt_q, cnt_d;
  logic [ENTRY_W-1:0] head_q, head_d;
  logic               push_ok, pop_ok;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign rdata_o = head_q;

  // A push into a full FIFO is still taken when a pop frees a slot that cycle
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_ptr_d = push_ok ? ((wr_ptr_q + AW'(1)) & PTR_MASK) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? ((rd_ptr_q + AW'(1)) & PTR_MASK) : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
    head_d = head_q;
    if (cnt_d != '0) begin
      // The new head may be the entry being written this very cycle
      head_d = (push_ok && (rd_ptr_d == wr_ptr_q)) ? wdata_i : mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      head_q   <= '0;
    end else begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      head_q   <= head_d;
    end
  end

endmodule

// File: rtl/spi_oled_rx.sv
// OLED SPI slave receiver: oversampled mode-0 bus, byte assembly tagged with DC,
// buffered into a small FIFO and offered on a valid/ready stream.
module spi_oled_rx
  import spi_oled_rx_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       SCLK,
  input  logic       CS,
  input  logic       DC,
  input  logic       DIN,
  output logic [7:0] RX_DATA,
  output logic       RX_DC,
  output logic       RX_VALID,
  input  logic       RX_READY,
  output logic       BUSY,
  output logic       OVERFLOW,
  output logic       FRAME_ERR,
  input  logic       CLR_ERR
);

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, dc_sync_q, din_sync_q;
  logic [SYNC_STAGES-1:0] live_q;
  logic                   sclk_s, cs_s, dc_s, din_s, sync_live;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sclk_sync_q <= {SYNC_STAGES{SYNC_RST_SCLK}};
      cs_sync_q   <= {SYNC_STAGES{SYNC_RST_CS}};
      dc_sync_q   <= {SYNC_STAGES{SYNC_RST_DC}};
      din_sync_q  <= {SYNC_STAGES{SYNC_RST_DIN}};
      live_q      <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], CS};
      dc_sync_q   <= {dc_sync_q[SYNC_STAGES-2:0], DC};
      din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], DIN};
      live_q      <= {live_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign dc_s      = dc_sync_q[SYNC_STAGES-1];
  assign din_s     = din_sync_q[SYNC_STAGES-1];
  // Synchronizer output reflects the pins rather than its reset value
  assign sync_live = live_q[SYNC_STAGES-1];

  rx_state_e            state_q;
  logic [2:0]           bit_cnt_q;
  logic [SPI_BITS-2:0]  shift_q;
  logic                 push_q;
  logic [ENTRY_W-1:0]   push_entry_q;
  logic                 sclk_prev_q;
  logic                 armed_q;
  logic                 overflow_q;
  logic                 frame_err_q;

  logic                 sclk_rise, last_bit, frame_evt, ovf_evt;
  logic [ENTRY_W-1:0]   head;
  logic                 fifo_full, fifo_empty;

  assign sclk_rise = sclk_s && !sclk_prev_q;
  assign last_bit  = (bit_cnt_q == 3'(SPI_BITS - 1));
  assign frame_evt = (state_q == ST_SHIFT) && cs_s && (bit_cnt_q != '0);
  assign ovf_evt   = push_q && fifo_full && !RX_READY;

  // armed_q: a real CS-high level has been seen, so the next CS low starts a frame
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      push_q       <= 1'b0;
      push_entry_q <= '0;
      sclk_prev_q  <= SYNC_RST_SCLK;
      armed_q      <= 1'b0;
      overflow_q   <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      sclk_prev_q <= sclk_s;
      push_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          bit_cnt_q <= '0;
          if (armed_q && !cs_s) begin
            state_q <= ST_SHIFT;
            armed_q <= 1'b0;
          end else if (sync_live && cs_s) begin
            armed_q <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (cs_s) begin
            bit_cnt_q <= '0;
            state_q   <= ST_IDLE;
          end else if (sclk_rise) begin
            shift_q   <= {shift_q[SPI_BITS-3:0], din_s};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (last_bit) begin
              push_q       <= 1'b1;
              push_entry_q <= {dc_s, shift_q, din_s};
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      if (frame_evt)    frame_err_q <= 1'b1;
      else if (CLR_ERR) frame_err_q <= 1'b0;

      if (ovf_evt)      overflow_q <= 1'b1;
      else if (CLR_ERR) overflow_q <= 1'b0;
    end
  end

  spi_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_n_i (RST_N),
    .push_i  (push_q),
    .wdata_i (push_entry_q),
    .pop_i   (RX_READY),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign RX_DATA   = head[SPI_BITS-1:0];
  assign RX_DC     = head[SPI_BITS];
  assign RX_VALID  = !fifo_empty;
  assign BUSY      = !cs_s || (bit_cnt_q != '0);
  assign OVERFLOW  = overflow_q;
  assign FRAME_ERR = frame_err_q;

endmodule

// File: tb/tb_spi_oled_rx.sv
// Directed bench for spi_oled_rx: table-driven burst plus hand-written corner sequences.
module tb_spi_oled_rx;

  localparam int DEPTH = 4;
  localparam int SS    = 2;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       SCLK = 1'b0;
  logic       CS = 1'b1;
  logic       DC = 1'b0;
  logic       DIN = 1'b0;
  logic       RX_READY = 1'b0;
  logic       CLR_ERR = 1'b0;
  logic [7:0] RX_DATA;
  logic       RX_DC, RX_VALID, BUSY, OVERFLOW, FRAME_ERR;

  int n_pass = 0;
  int n_total = 0;
  logic [8:0] rx_q[$];

  typedef struct {
    logic [7:0] din;
    logic       dc;
    logic [8:0] exp;
  } vec_t;
  vec_t vec[4];

  always #5 CLK = ~CLK;

  spi_oled_rx #(
    .FIFO_DEPTH  (DEPTH),
    .SYNC_STAGES (SS)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .SCLK      (SCLK),
    .CS        (CS),
    .DC        (DC),
    .DIN       (DIN),
    .RX_DATA   (RX_DATA),
    .RX_DC     (RX_DC),
    .RX_VALID  (RX_VALID),
    .RX_READY  (RX_READY),
    .BUSY      (BUSY),
    .OVERFLOW  (OVERFLOW),
    .FRAME_ERR (FRAME_ERR),
    .CLR_ERR   (CLR_ERR)
  );

  // A handshake seen at the falling edge is the pop taken at the next rising edge
  always @(negedge CLK) begin
    if (RX_VALID && RX_READY) rx_q.push_back({RX_DC, RX_DATA});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic send_bit(input logic b, input logic dc);
    SCLK = 1'b0; DIN = b; DC = dc;
    repeat (4) @(negedge CLK);
    SCLK = 1'b1;
    repeat (4) @(negedge CLK);
  endtask

  // Leaves SCLK just raised so the caller can count cycles from the 8th edge
  task automatic send_bit_rise(input logic b, input logic dc);
    SCLK = 1'b0; DIN = b; DC = dc;
    repeat (4) @(negedge CLK);
    SCLK = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic dc);
    for (int i = 7; i >= 0; i--) send_bit(b[i], dc);
  endtask

  task automatic cs_low();
    @(negedge CLK);
    CS = 1'b0;
    repeat (4) @(negedge CLK);
  endtask

  task automatic cs_high();
    SCLK = 1'b0;
    repeat (4) @(negedge CLK);
    CS = 1'b1;
    repeat (8) @(negedge CLK);
  endtask

  task automatic set_ready(input logic v);
    @(posedge CLK);
    #1 RX_READY = v;
  endtask

  task automatic clr_pulse();
    @(negedge CLK); CLR_ERR = 1'b1;
    @(negedge CLK); CLR_ERR = 1'b0;
    @(negedge CLK);
  endtask

  task automatic wait_entries(input int n, input string name);
    for (int i = 0; i < 400 && rx_q.size() < n; i++) @(negedge CLK);
    repeat (10) @(negedge CLK);
    chk(name, rx_q.size(), n);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;

    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    repeat (4) @(negedge CLK);
    chk("rst_data", RX_DATA, 8'h00);
    chk("rst_dc", RX_DC, 1'b0);
    chk("rst_valid", RX_VALID, 1'b0);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_ovf", OVERFLOW, 1'b0);
    chk("rst_ferr", FRAME_ERR, 1'b0);

    // Single command byte with exact latency on RX_VALID
    cs_low();
    chk("cmd_busy_cs", BUSY, 1'b1);
    b = 8'hAE;
    for (int i = 7; i >= 1; i--) send_bit(b[i], 1'b0);
    send_bit_rise(b[0], 1'b0);
    repeat (SS + 1) @(posedge CLK);
    #1 chk("cmd_valid_early", RX_VALID, 1'b0);
    @(posedge CLK);
    #1 chk("cmd_valid_on_time", RX_VALID, 1'b1);
    chk("cmd_data", RX_DATA, 8'hAE);
    chk("cmd_dc", RX_DC, 1'b0);
    repeat (3) @(negedge CLK);
    cs_high();
    chk("cmd_busy_idle", BUSY, 1'b0);
    chk("cmd_ovf", OVERFLOW, 1'b0);
    chk("cmd_ferr", FRAME_ERR, 1'b0);
    set_ready(1'b1);
    wait_entries(1, "cmd_count");
    if (rx_q.size() > 0) chk("cmd_entry", rx_q[0], 9'h0AE);
    set_ready(1'b0);
    rx_q.delete();

    // Burst of data bytes in one CS assertion, consumer always ready
    vec[0] = '{8'h01, 1'b1, 9'h101};
    vec[1] = '{8'h80, 1'b1, 9'h180};
    vec[2] = '{8'hFF, 1'b1, 9'h1FF};
    vec[3] = '{8'h5A, 1'b1, 9'h15A};
    set_ready(1'b1);
    cs_low();
    for (int i = 0; i < 4; i++) send_byte(vec[i].din, vec[i].dc);
    cs_high();
    wait_entries(4, "burst_count");
    for (int i = 0; i < 4 && i < rx_q.size(); i++) chk($sformatf("burst_%0d", i), rx_q[i], vec[i].exp);
    chk("burst_ovf", OVERFLOW, 1'b0);
    set_ready(1'b0);
    rx_q.delete();

    // Overflow: DEPTH+1 bytes with no consumer
    cs_low();
    for (int i = 0; i < DEPTH + 1; i++) send_byte(8'(16 + i), 1'b0);
    cs_high();
    chk("ovf_set", OVERFLOW, 1'b1);
    chk("ovf_valid", RX_VALID, 1'b1);
    chk("ovf_head", RX_DATA, 8'h10);
    clr_pulse();
    chk("ovf_clr", OVERFLOW, 1'b0);
    set_ready(1'b1);
    wait_entries(DEPTH, "ovf_count");
    for (int i = 0; i < DEPTH && i < rx_q.size(); i++) chk($sformatf("ovf_drain_%0d", i), rx_q[i], 9'(16 + i));
    set_ready(1'b0);
    rx_q.delete();

    // Framing: CS released after 5 bits, then a clean byte
    cs_low();
    b = 8'hF0;
    for (int i = 7; i >= 3; i--) send_bit(b[i], 1'b0);
    chk("frm_busy_partial", BUSY, 1'b1);
    cs_high();
    chk("frm_ferr", FRAME_ERR, 1'b1);
    chk("frm_no_entry", RX_VALID, 1'b0);
    chk("frm_busy_idle", BUSY, 1'b0);
    set_ready(1'b1);
    cs_low();
    send_byte(8'h3C, 1'b0);
    cs_high();
    wait_entries(1, "frm_count");
    if (rx_q.size() > 0) chk("frm_entry", rx_q[0], 9'h03C);
    chk("frm_ferr_sticky", FRAME_ERR, 1'b1);
    clr_pulse();
    chk("frm_clr", FRAME_ERR, 1'b0);
    set_ready(1'b0);
    rx_q.delete();

    // Full FIFO with a pop in the same cycle as the push of the next byte
    cs_low();
    for (int i = 0; i < DEPTH; i++) send_byte(8'(8'h21 + i), 1'b1);
    chk("sim_full_valid", RX_VALID, 1'b1);
    chk("sim_head_a", RX_DATA, 8'h21);
    b = 8'h25;
    for (int i = 7; i >= 1; i--) send_bit(b[i], 1'b1);
    chk("sim_head_stable", RX_DATA, 8'h21);
    chk("sim_ovf_before", OVERFLOW, 1'b0);
    send_bit_rise(b[0], 1'b1);
    repeat (SS + 1) @(posedge CLK);
    #1 RX_READY = 1'b1;
    repeat (3) @(negedge CLK);
    cs_high();
    wait_entries(DEPTH + 1, "sim_count");
    for (int i = 0; i < DEPTH + 1 && i < rx_q.size(); i++) chk($sformatf("sim_order_%0d", i), rx_q[i], {1'b1, 8'(8'h21 + i)});
    chk("sim_ovf", OVERFLOW, 1'b0);
    set_ready(1'b0);
    rx_q.delete();

    // Reset mid-byte with two queued entries
    cs_low();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    b = 8'h99;
    for (int i = 7; i >= 4; i--) send_bit(b[i], 1'b0);
    chk("rstm_valid_before", RX_VALID, 1'b1);
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    chk("rstm_valid", RX_VALID, 1'b0);
    chk("rstm_data", RX_DATA, 8'h00);
    chk("rstm_dc", RX_DC, 1'b0);
    chk("rstm_busy", BUSY, 1'b0);
    chk("rstm_ovf", OVERFLOW, 1'b0);
    chk("rstm_ferr", FRAME_ERR, 1'b0);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    // CS is still low from before reset: these bits must be ignored
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    chk("rstm_ignored", RX_VALID, 1'b0);
    cs_high();
    chk("rstm_no_ferr", FRAME_ERR, 1'b0);
    set_ready(1'b1);
    cs_low();
    send_byte(8'h5A, 1'b1);
    cs_high();
    wait_entries(1, "rstm_count");
    if (rx_q.size() > 0) chk("rstm_entry", rx_q[0], 9'h15A);
    set_ready(1'b0);
    rx_q.delete();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/spi_oled_rx.md
# spi_oled_rx

SPI slave receiver for the OLED command/data link: oversamples the 4-wire bus (SCLK, CS, DC, DIN) on the system clock and reassembles 8-bit command/data bytes, each tagged with its DC flag. Received bytes are buffered in a small FIFO and offered on a valid/ready stream. It serves as the display-side endpoint, used for loopback checking of the OLED SPI transmitter and as the front end of a display emulator.

## Interface
- FIFO_DEPTH, 4, byte FIFO entries; power of two, ≥2
- SYNC_STAGES, 2, synchronizer flops on each bus input; ≥2
- CLK  input  1  system clock; all logic on rising edge
- RST_N  input  1  reset; asynchronous, active-low
- SCLK  input  1  SPI clock from master, asynchronous to CLK, idle low
- CS  input  1  chip select, active low
- DC  input  1  0 = command, 1 = data
- DIN  input  1  serial data, MSB first
- RX_DATA  output  8  head-of-FIFO byte
- RX_DC  output  1  DC flag of head byte
- RX_VALID  output  1  FIFO non-empty
- RX_READY  input  1  consumer accepts head entry
- BUSY  output  1  CS asserted (synchronized) or a byte partially shifted
- OVERFLOW  output  1  sticky: completed byte dropped, FIFO full
- FRAME_ERR  output  1  sticky: CS released mid-byte
- CLR_ERR  input  1  synchronous clear of OVERFLOW and FRAME_ERR

## Operation
- SCLK, CS, DC, DIN each pass through SYNC_STAGES flops; synchronizer reset values SCLK=0, CS=1, DC=0, DIN=0 (idle, no false edge after reset).
- Rising SCLK edge = synchronized SCLK 1 with previous synchronized value 0; DIN/DC sampled from the same synchronizer stage.
- SPI mode 0, MSB first. 3-bit bit counter, 8-bit shift register.
- State machine:
  - IDLE: synchronized CS high; counter 0. CS low -> SHIFT.
  - SHIFT: on each rising SCLK edge shift DIN into LSB, counter+1. On 8th edge the completed byte plus DC sampled at that edge is pushed into the FIFO, counter wraps to 0, stays in SHIFT (back-to-back bytes within one CS assertion). CS high with counter 0 -> IDLE; CS high with counter 1..7 -> discard partial byte, set FRAME_ERR, -> IDLE.
- SCLK edges while CS high ignored. A rising edge in the same CLK cycle as CS deassertion is ignored.
- Push with FIFO full and no simultaneous pop: byte dropped, OVERFLOW set, FIFO unchanged. Full with simultaneous pop: push accepted, no overflow.
- Pop when RX_VALID && RX_READY at rising CLK.
- CLR_ERR clears both sticky flags; an error event in the same cycle wins (flag stays 1).
- BUSY = synchronized CS low, or counter ≠ 0.

## Timing
- Reset values: RX_DATA 0x00, RX_DC 0, RX_VALID 0, BUSY 0, OVERFLOW 0, FRAME_ERR 0; FIFO empty, counter 0, state IDLE.
- Input requirement: SCLK high and low phases each ≥ 2 CLK periods (SCLK ≤ CLK/4); DIN/DC stable ≥ 2 CLK periods around SCLK rising edge.
- Latency: RX_VALID rises exactly SYNC_STAGES+2 CLK cycles after the 8th SCLK rising edge reaches the pin (FIFO was empty).
- RX_DATA/RX_DC registered; stable while RX_VALID && !RX_READY; next entry visible the cycle after a pop.
- Sustained throughput: one byte per 8 SCLK periods; consumer holding RX_READY high never causes overflow.
- Flags update one CLK after the causing event is detected.
- RST_N asserted mid-byte: partial byte and FIFO contents discarded immediately; after release, receiver waits for CS high->low before accepting bits (IDLE only entered via synchronized CS high).

## Structure
- Shared package: SPI bit count (8), entry width (9 = {DC, byte}), state encoding (IDLE, SHIFT), synchronizer reset constants.
- One sub-module: spi_rx_fifo — synchronous FIFO, FIFO_DEPTH × 9 bits, push/pop/full/empty, registered head output; pointer wrap by power-of-two masking.
- Synchronizers, edge detect, shifter, counter and FSM stay in spi_oled_rx.

## Test plan
- Single command: CS low, DC=0, shift 0xAE at CLK/8, CS high -> one entry RX_DATA=0xAE, RX_DC=0, RX_VALID at SYNC_STAGES+2 cycles after 8th edge; BUSY low after CS release; no flags.
- Burst: one CS assertion, DC=1, bytes 0x01,0x80,0xFF,0x5A, RX_READY=1 -> four entries in order, all RX_DC=1, no overflow.
- Overflow: RX_READY=0, send FIFO_DEPTH+1 bytes (0x10..0x14 for depth 4) -> FIFO holds 0x10..0x13, OVERFLOW=1; CLR_ERR pulse -> OVERFLOW=0; drain returns 0x10..0x13 only.
- Framing: CS high after 5 bits, then full byte 0x3C -> FRAME_ERR=1, only 0x3C enqueued.
- Backpressure/simultaneity: FIFO full, RX_READY=1 in cycle of 8th-bit push -> no OVERFLOW, ordering preserved; RX_DATA stable while RX_READY=0.
- Reset mid-byte: RST_N low after 4 bits with 2 queued entries -> all outputs at reset values; next complete byte after fresh CS assertion received correctly.
